text_memory_loader: RTL and testbench

Write-side companion to the text memory fetch path: a byte-stream programmer that assembles little-endian 32-bit instruction words and writes them sequentially into the text memory's write port. It sits between a host byte source (debug link or boot ROM streamer) and the text memory. While loading, it asserts `busy`, which holds the core in reset so instruction fetch never sees a partially written image.

---
 rtl/text_memory_loader_if.sv | 25 ++
 rtl/text_memory_loader.sv | 53 +++++
 tb/tb_text_memory_loader.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/text_memory_loader_if.sv
// text_memory_loader_if: host byte stream plus text memory write port and load status
//   master : loader side (consumes bytes, drives memory write port and status)
//   slave  : host/memory side
interface text_memory_loader_if #(
  parameter int ADDR_WIDTH = 14
);
  logic                  start;
  logic [ADDR_WIDTH:0]   load_words;
  logic                  byte_valid;
  logic [7:0]            byte_data;
  logic                  byte_ready;
  logic [ADDR_WIDTH-1:0] mem_address;
  logic [31:0]           mem_data;
  logic                  mem_write_enable;
  logic                  busy;
  logic                  done;
  modport master (
    input  start, load_words, byte_valid, byte_data,
    output byte_ready, mem_address, mem_data, mem_write_enable, busy, done
  );
  modport slave (
    output start, load_words, byte_valid, byte_data,
    input  byte_ready, mem_address, mem_data, mem_write_enable, busy, done
  );
endinterface

// File: rtl/text_memory_loader.sv
// text_memory_loader: assembles a little-endian byte stream into 32-bit words and writes them to text memory
//   clock, reset : system clock, asynchronous active-high reset
//   bus          : start/load_words request, byte stream in, memory write port and busy/done status out
module text_memory_loader #(
  parameter int ADDR_WIDTH = 14
) (
  input logic clock,
  input logic reset,
  text_memory_loader_if.master bus
);
  localparam logic [1:0] IDLE = 2'd0, COLLECT = 2'd1, WRITE = 2'd2, FINISH = 2'd3;
  logic [1:0]            state, index;
  logic [ADDR_WIDTH:0]   count, target, count_next;
  logic [ADDR_WIDTH-1:0] address;
  logic [31:0]           data;
  // one bit wider than the address so a full-memory load still reaches its target
  assign count_next = count + 1'b1;
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state   <= IDLE;
      index   <= '0;
      count   <= '0;
      target  <= '0;
      address <= '0;
      data    <= '0;
    end else case (state)
      IDLE: if (bus.start) begin
        target  <= bus.load_words;
        count   <= '0;
        address <= '0;
        index   <= '0;
        state   <= bus.load_words == '0 ? FINISH : COLLECT;
      end
      COLLECT: if (bus.byte_valid) begin
        data[{index, 3'b000} +: 8] <= bus.byte_data;
        index <= index + 1'b1;
        if (index == 2'd3) state <= WRITE;
      end
      WRITE: begin
        count   <= count_next;
        address <= address + 1'b1;
        index   <= '0;
        state   <= count_next == target ? FINISH : COLLECT;
      end
      FINISH: state <= IDLE;
    endcase
  assign bus.byte_ready       = state == COLLECT;
  assign bus.mem_write_enable = state == WRITE;
  assign bus.busy             = state == COLLECT || state == WRITE;
  assign bus.done             = state == FINISH;
  assign bus.mem_address      = address;
  assign bus.mem_data         = data;
endmodule

// File: tb/tb_text_memory_loader.sv
// tb_text_memory_loader: directed scoreboard bench for text_memory_loader at ADDR_WIDTH 14 and 2
module tb_text_memory_loader;
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  text_memory_loader_if #(.ADDR_WIDTH(14)) a_if ();
  text_memory_loader_if #(.ADDR_WIDTH(2))  b_if ();

  text_memory_loader #(.ADDR_WIDTH(14)) ua (.clock(clock), .reset(reset), .bus(a_if.master));
  text_memory_loader #(.ADDR_WIDTH(2))  ub (.clock(clock), .reset(reset), .bus(b_if.master));

  typedef struct {
    int          sel;
    logic [13:0] addr;
    logic [31:0] data;
  } exp_t;

  exp_t        q[$];
  exp_t        e;
  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  int          wr_cnt[2] = '{0, 0};
  int          t_first[2] = '{0, 0};
  int          t_done[2] = '{0, 0};
  logic [1:0]  we, rdy, bsy, dn;
  logic [1:0]  prev_we = 2'b00;
  logic [1:0]  prev_busy = 2'b00;
  logic [13:0] addr[2];
  logic [31:0] data[2];

  assign we      = {b_if.mem_write_enable, a_if.mem_write_enable};
  assign rdy     = {b_if.byte_ready, a_if.byte_ready};
  assign bsy     = {b_if.busy, a_if.busy};
  assign dn      = {b_if.done, a_if.done};
  assign addr[0] = a_if.mem_address;
  assign addr[1] = {12'b0, b_if.mem_address};
  assign data[0] = a_if.mem_data;
  assign data[1] = b_if.mem_data;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  always @(posedge clock) cyc <= cyc + 1;

  // scoreboard: every strobe must match the oldest pushed expectation
  always @(negedge clock) begin
    for (int i = 0; i < 2; i++) begin
      if (we[i]) begin
        check("strobe_one_cycle", 64'(prev_we[i]), 0);
        if (q.size() == 0) check("unexpected_write", 64'(we[i]), 0);
        else begin
          e = q.pop_front();
          check("wr_sel", i, e.sel);
          check("wr_addr", addr[i], e.addr);
          check("wr_data", data[i], e.data);
        end
        wr_cnt[i]++;
      end
      if (rdy[i] && !prev_busy[i]) t_first[i] = cyc;
      if (dn[i]) t_done[i] = cyc;
    end
    prev_we   = we;
    prev_busy = bsy;
  end

  task automatic set_valid(input int s, input logic v, input logic [7:0] b);
    if (s == 0) begin a_if.byte_valid = v; a_if.byte_data = b; end
    else begin b_if.byte_valid = v; b_if.byte_data = b; end
  endtask

  task automatic do_start(input int s, input int n);
    if (s == 0) begin a_if.start = 1'b1; a_if.load_words = 15'(n); end
    else begin b_if.start = 1'b1; b_if.load_words = 3'(n); end
    @(posedge clock); #1;
    if (s == 0) begin a_if.start = 1'b0; a_if.load_words = 15'($urandom); end
    else begin b_if.start = 1'b0; b_if.load_words = 3'($urandom); end
  endtask

  task automatic send_byte(input int s, input logic [7:0] b);
    logic ok = 1'b0;
    set_valid(s, 1'b1, b);
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clock);
      ok = rdy[s];
    end
    check("byte_accept", 64'(ok), 1);
    @(posedge clock); #1;
  endtask

  task automatic send_word(input int s, input int a, input logic [31:0] w, input bit stall);
    q.push_back('{s, 14'(a), w});
    for (int k = 0; k < 4; k++) begin
      send_byte(s, w[8*k +: 8]);
      if (stall) begin
        set_valid(s, 1'b0, 8'h00);
        @(posedge clock); #1;
      end
    end
  endtask

  task automatic wait_done(input int s);
    logic ok = 1'b0;
    set_valid(s, 1'b0, 8'h00);
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clock);
      ok = dn[s];
    end
    check("done_seen", 64'(ok), 1);
    @(posedge clock); #1;
  endtask

  task automatic check_zero(input int s);
    check("zero_ready", 64'(rdy[s]), 0);
    check("zero_busy", 64'(bsy[s]), 0);
    check("zero_we", 64'(we[s]), 0);
    check("zero_done", 64'(dn[s]), 0);
    check("zero_addr", 64'(addr[s]), 0);
    check("zero_data", 64'(data[s]), 0);
  endtask

  initial begin
    a_if.start = 1'b0; a_if.load_words = '0; a_if.byte_valid = 1'b0; a_if.byte_data = '0;
    b_if.start = 1'b0; b_if.load_words = '0; b_if.byte_valid = 1'b0; b_if.byte_data = '0;
    repeat (2) @(negedge clock);
    check_zero(0);
    check_zero(1);
    @(posedge clock); #1;
    reset = 1'b0;
    a_if.byte_valid = 1'b1;
    b_if.byte_valid = 1'b1;
    repeat (3) begin
      @(negedge clock);
      check("idle_ready", 64'(rdy), 0);
      check("idle_busy", 64'(bsy), 0);
    end
    @(posedge clock); #1;
    a_if.byte_valid = 1'b0;
    b_if.byte_valid = 1'b0;
    check("idle_writes", wr_cnt[0] + wr_cnt[1], 0);

    do_start(0, 2);
    send_word(0, 0, 32'h00000013, 1'b0);
    send_word(0, 1, 32'h00100093, 1'b0);
    wait_done(0);
    check("done_latency", t_done[0] - t_first[0], 10);
    check("writes_b2b", wr_cnt[0], 2);
    check("hold_addr", 64'(addr[0]), 2);
    check("hold_data", 64'(data[0]), 32'h00100093);
    check("idle_after_done", {bsy[0], dn[0], rdy[0]}, 0);

    do_start(0, 2);
    send_word(0, 0, 32'h00000013, 1'b1);
    send_word(0, 1, 32'h00100093, 1'b1);
    wait_done(0);
    check("writes_stall", wr_cnt[0], 4);

    do_start(0, 0);
    @(negedge clock);
    check("len0_done", 64'(dn[0]), 1);
    check("len0_busy", 64'(bsy[0]), 0);
    @(negedge clock);
    check("len0_done_clear", 64'(dn[0]), 0);
    check("len0_busy_after", 64'(bsy[0]), 0);
    check("len0_writes", wr_cnt[0], 4);
    @(posedge clock); #1;

    do_start(0, 2);
    send_byte(0, 8'hAA);
    send_byte(0, 8'hBB);
    reset = 1'b1;
    #1;
    check_zero(0);
    a_if.byte_valid = 1'b0;
    @(posedge clock); #1;
    reset = 1'b0;
    do_start(0, 1);
    send_word(0, 0, 32'h44332211, 1'b0);
    wait_done(0);
    check("writes_after_reset", wr_cnt[0], 5);
    check("queue_empty_a", q.size(), 0);

    do_start(1, 4);
    send_word(1, 0, 32'h03020100, 1'b0);
    b_if.start = 1'b1;
    b_if.load_words = 3'd1;
    send_word(1, 1, 32'h13121110, 1'b0);
    b_if.start = 1'b0;
    send_word(1, 2, 32'h23222120, 1'b1);
    send_word(1, 3, 32'h33323130, 1'b0);
    wait_done(1);
    check("wrap_addr", 64'(addr[1]), 0);
    check("wrap_writes", wr_cnt[1], 4);
    check("wrap_idle", {bsy[1], dn[1]}, 0);
    check("queue_empty_b", q.size(), 0);
    check("no_stray_a", wr_cnt[0], 5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
